data_source: RTL and testbench

AXI4-Stream transmitter that generates framed test traffic: a programmed number of packets of programmed length, each an incrementing 32-bit word sequence, with an optional idle gap between packets. It is the upstream counterpart of the data sink block and drives the same `axi4s_if` stream. Testbenches and on-chip loopback tests use it as a traffic generator.

---
 rtl/data_source_pkg.sv | 9 +
 rtl/axi4s_if.sv | 16 +
 rtl/data_source.sv | 134 +++++++++++++
 tb/tb_data_source.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_source_pkg.sv
// rtl/data_source_pkg.sv - shared types and default widths for the framed traffic generator
package data_source_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} src_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 16;

endpackage

// File: rtl/axi4s_if.sv
// rtl/axi4s_if.sv - stream bundle shared by the traffic source and sink
interface axi4s_if
    import data_source_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tready;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/data_source.sv
// rtl/data_source.sv - generates a run of framed packets carrying an incrementing word sequence
module data_source #(
    parameter int DATA_WIDTH = data_source_pkg::DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = data_source_pkg::DEF_LEN_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] SEED,
    input  logic [LEN_WIDTH-1:0]  PKT_LEN,
    input  logic [LEN_WIDTH-1:0]  NUM_PKTS,
    input  logic [LEN_WIDTH-1:0]  GAP,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [LEN_WIDTH-1:0]  PKT_CNT,
    axi4s_if.master               AXIS_PORT
);

    localparam logic [1:0] ST_IDLE   = data_source_pkg::IDLE;
    localparam logic [1:0] ST_SEND   = data_source_pkg::SEND;
    localparam logic [1:0] ST_GAP    = data_source_pkg::GAP;
    localparam logic [1:0] ST_FINISH = data_source_pkg::FINISH;

    localparam logic [LEN_WIDTH-1:0]  L_ONE = LEN_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] D_ONE = DATA_WIDTH'(1);

    logic [1:0]            state;
    logic                  tvalid_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tlast_q;
    logic                  busy_q;
    logic                  done_q;
    logic [LEN_WIDTH-1:0]  pkt_cnt_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  num_q;
    logic [LEN_WIDTH-1:0]  gap_q;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [LEN_WIDTH-1:0]  gap_cnt;
    logic [LEN_WIDTH-1:0]  eff_len;

    assign eff_len = (PKT_LEN == '0) ? L_ONE : PKT_LEN;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= ST_IDLE;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pkt_cnt_q <= '0;
            len_q     <= '0;
            num_q     <= '0;
            gap_q     <= '0;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        tdata_q   <= SEED;
                        len_q     <= eff_len;
                        num_q     <= NUM_PKTS;
                        gap_q     <= GAP;
                        pkt_cnt_q <= '0;
                        beat_cnt  <= '0;
                        busy_q    <= 1'b1;
                        if (NUM_PKTS == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            state    <= ST_SEND;
                            tvalid_q <= 1'b1;
                            tlast_q  <= (eff_len == L_ONE);
                        end
                    end
                end
                ST_SEND: begin
                    if (AXIS_PORT.tready) begin
                        tdata_q <= tdata_q + D_ONE;
                        if (tlast_q) begin
                            pkt_cnt_q <= pkt_cnt_q + L_ONE;
                            beat_cnt  <= '0;
                            if (pkt_cnt_q + L_ONE == num_q) begin
                                // DONE is raised on the way into FINISH so it lands right after the last beat
                                state    <= ST_FINISH;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                done_q   <= 1'b1;
                                busy_q   <= 1'b0;
                            end else if (gap_q != '0) begin
                                state    <= ST_GAP;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                gap_cnt  <= L_ONE;
                            end else begin
                                tlast_q <= (len_q == L_ONE);
                            end
                        end else begin
                            beat_cnt <= beat_cnt + L_ONE;
                            tlast_q  <= (beat_cnt + L_ONE == len_q - L_ONE);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == gap_q) begin
                        state    <= ST_SEND;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (len_q == L_ONE);
                    end else begin
                        gap_cnt <= gap_cnt + L_ONE;
                    end
                end
                default: begin
                    // An empty run arrives here still busy and pulses DONE from this state instead
                    if (busy_q) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign AXIS_PORT.tvalid = tvalid_q;
    assign AXIS_PORT.tdata  = tdata_q;
    assign AXIS_PORT.tlast  = tlast_q;
    assign BUSY             = busy_q;
    assign DONE             = done_q;
    assign PKT_CNT          = pkt_cnt_q;

endmodule

// File: tb/tb_data_source.sv
// tb/tb_data_source.sv - directed self-checking bench for the framed traffic generator
module tb_data_source;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic [31:0] seed;
    logic [15:0] pkt_len;
    logic [15:0] num_pkts;
    logic [15:0] gap;
    logic        busy;
    logic        done;
    logic [15:0] pkt_cnt;

    axi4s_if #(.DATA_WIDTH(32)) axis ();

    data_source #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .ACLK      (aclk),
        .ARESETN   (aresetn),
        .START     (start),
        .SEED      (seed),
        .PKT_LEN   (pkt_len),
        .NUM_PKTS  (num_pkts),
        .GAP       (gap),
        .BUSY      (busy),
        .DONE      (done),
        .PKT_CNT   (pkt_cnt),
        .AXIS_PORT (axis)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];
    int          q_cyc[$];
    int          cyc = 0;
    int          done_cyc = 0;
    bit          done_seen = 0;
    bit          pend = 0;
    logic [31:0] pdata;
    logic        plast;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transfers and handshake stability are observed mid-cycle, away from the active edge
    always @(negedge aclk) begin
        cyc++;
        if (!aresetn) begin
            pend = 0;
        end else begin
            if (pend) begin
                chk("stable_tvalid", {31'd0, axis.tvalid}, 32'd1);
                chk("stable_tdata", axis.tdata, pdata);
                chk("stable_tlast", {31'd0, axis.tlast}, {31'd0, plast});
            end
            pend  = axis.tvalid && !axis.tready;
            pdata = axis.tdata;
            plast = axis.tlast;
            if (axis.tvalid && axis.tready) begin
                q_data.push_back(axis.tdata);
                q_last.push_back(axis.tlast);
                q_cyc.push_back(cyc);
            end
            if (done && !done_seen) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] s, input logic [15:0] l,
                             input logic [15:0] n, input logic [15:0] g);
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
        done_seen = 0;
        seed = s; pkt_len = l; num_pkts = n; gap = g;
        start = 1'b1;
        tick();
        start = 1'b0;
        seed = 32'hDEAD_BEEF; pkt_len = 16'd7; num_pkts = 16'd9; gap = 16'd3;
    endtask

    task automatic wait_done(input bit bp);
        int k;
        k = 0;
        while (!done_seen && k < 500) begin
            tick();
            if (bp) axis.tready = 1'($urandom_range(0, 1));
            k++;
        end
        axis.tready = 1'b1;
        chk("done_timeout", {31'd0, done_seen}, 32'd1);
    endtask

    task automatic check_beats(input logic [31:0] s, input int n, input int len);
        logic [31:0] exp_d;
        chk("beat_count", q_data.size(), n);
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            exp_d = s + i;
            chk($sformatf("beat%0d_data", i), q_data[i], exp_d);
            chk($sformatf("beat%0d_last", i), {31'd0, q_last[i]}, {31'd0, 1'((i % len) == len - 1)});
        end
    endtask

    initial begin
        aresetn = 1'b0;
        start = 1'b0; seed = '0; pkt_len = '0; num_pkts = '0; gap = '0;
        axis.tready = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
        chk("rst_tdata", axis.tdata, 32'd0);
        chk("rst_tlast", {31'd0, axis.tlast}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        aresetn = 1'b1;
        tick();

        // Basic run: two 4-beat packets back to back
        start_run(32'd0, 16'd4, 16'd2, 16'd0);
        chk("basic_tvalid_after_start", {31'd0, axis.tvalid}, 32'd1);
        chk("basic_busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(0);
        check_beats(32'd0, 8, 4);
        if (q_cyc.size() == 8) chk("basic_back_to_back", q_cyc[7] - q_cyc[0], 32'd7);
        if (q_cyc.size() == 8) chk("basic_done_timing", done_cyc - q_cyc[7], 32'd1);
        chk("basic_busy_at_done", {31'd0, busy}, 32'd0);
        chk("basic_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
        tick();
        chk("basic_done_pulse", {31'd0, done}, 32'd0);
        tick();

        // Same run under random backpressure
        start_run(32'd0, 16'd4, 16'd2, 16'd0);
        wait_done(1);
        check_beats(32'd0, 8, 4);
        chk("bp_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
        repeat (2) tick();

        // Idle gaps of 5 between packets, none after the last
        start_run(32'd0, 16'd3, 16'd3, 16'd5);
        wait_done(0);
        check_beats(32'd0, 9, 3);
        if (q_cyc.size() == 9) begin
            chk("gap_in_pkt", q_cyc[2] - q_cyc[0], 32'd2);
            chk("gap_after_2", q_cyc[3] - q_cyc[2], 32'd6);
            chk("gap_after_5", q_cyc[6] - q_cyc[5], 32'd6);
            chk("gap_none_after_8", done_cyc - q_cyc[8], 32'd1);
        end
        chk("gap_pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
        repeat (2) tick();

        // Empty run
        start_run(32'h55, 16'd4, 16'd0, 16'd0);
        chk("empty_busy", {31'd0, busy}, 32'd1);
        chk("empty_tvalid", {31'd0, axis.tvalid}, 32'd0);
        chk("empty_done_early", {31'd0, done}, 32'd0);
        tick();
        chk("empty_done", {31'd0, done}, 32'd1);
        chk("empty_busy_fall", {31'd0, busy}, 32'd0);
        chk("empty_no_beats", q_data.size(), 32'd0);
        chk("empty_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        repeat (3) tick();

        // Zero length means single-beat packets
        start_run(32'd100, 16'd0, 16'd3, 16'd0);
        wait_done(0);
        check_beats(32'd100, 3, 1);
        chk("len0_pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
        repeat (2) tick();

        // Data wraps past all-ones
        start_run(32'hFFFF_FFFE, 16'd4, 16'd1, 16'd0);
        wait_done(0);
        check_beats(32'hFFFF_FFFE, 4, 4);
        repeat (2) tick();

        // A second START mid-run is ignored
        start_run(32'h50, 16'd4, 16'd2, 16'd0);
        repeat (2) tick();
        seed = 32'h999; pkt_len = 16'd1; num_pkts = 16'd5; gap = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(0);
        check_beats(32'h50, 8, 4);
        chk("restart_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
        repeat (2) tick();

        // Reset on beat 2 of 8, then a fresh run
        start_run(32'h10, 16'd8, 16'd1, 16'd0);
        begin
            int k;
            k = 0;
            while (q_data.size() < 2 && k < 50) begin
                tick();
                k++;
            end
        end
        chk("mid_reached_beat2", axis.tdata, 32'h12);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
        chk("mid_rst_tdata", axis.tdata, 32'd0);
        chk("mid_rst_tlast", {31'd0, axis.tlast}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        start_run(32'h200, 16'd2, 16'd1, 16'd0);
        wait_done(0);
        check_beats(32'h200, 2, 2);
        chk("fresh_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
